// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encoding and default operand width for the
// bit-serial adder/subtractor.
package serial_addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_fulladder.sv
// fulladder: one-bit combinational full adder cell, reused by the serial
// datapath once per clock.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  logic w_p;

  assign w_p       = a ^ b;
  assign sum       = w_p ^ carry_in;
  assign carry_out = (a & b) | (carry_in & w_p);

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder, one bit per clock LSB first, driving a
// single fulladder cell. Result and carry-out are registered and only change
// at the edge that raises done.
// Optional feature macro: SERIAL_ADDSUB_SUB_EN adds the op port
// (op=1 computes a - b; carry_out=1 then means no borrow).
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef SERIAL_ADDSUB_SUB_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_sub;
  logic             w_load;
  logic             w_last;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_acc_next;

`ifdef SERIAL_ADDSUB_SUB_EN
  assign w_sub = op;
`else
  assign w_sub = 1'b0;
`endif

  // A new operation is accepted only when not mid-computation.
  assign w_load = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last = (r_state == RUN) && (r_cnt == LAST_BIT);

  fulladder u_fa (
    .a         (r_opa[0]),
    .b         (r_opb[0]),
    .carry_in  (r_carry),
    .sum       (w_fa_sum),
    .carry_out (w_fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  // Written as shift/OR so it also holds for WIDTH=1.
  assign w_acc_next = (r_acc >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = start ? RUN : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand shifters, carry, accumulator and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_opa   <= a;
      r_opb   <= w_sub ? ~b : b;
      r_carry <= w_sub ? 1'b1 : carry_in;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_opa   <= r_opa >> 1;
      r_opb   <= r_opb >> 1;
      r_carry <= w_fa_cout;
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Result registers: written only on the final bit, never with a partial value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_acc_next;
      r_cout <= w_fa_cout;
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: table of operations on an 8-bit instance,
// hand sequences for held start, start during RUN and mid-run reset, plus an
// exhaustive sweep of a 1-bit instance.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       op8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       op1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] prev_sum = 8'h00;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .carry_in  (cin8),
`ifdef SERIAL_ADDSUB_SUB_EN
    .op        (op8),
`endif
    .busy      (busy8),
    .done      (done8),
    .sum       (sum8),
    .carry_out (cout8)
  );

  serial_addsub #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .a         (a1),
    .b         (b1),
    .carry_in  (cin1),
`ifdef SERIAL_ADDSUB_SUB_EN
    .op        (op1),
`endif
    .busy      (busy1),
    .done      (done1),
    .sum       (sum1),
    .carry_out (cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       op;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One operation on the 8-bit instance, optionally with a stray start pulse
  // (different operands) injected while it is running.
  task automatic run8(input vec_t v, input bit glitch);
    int lat;
    int busy_cnt;
    bit sum_moved;
    lat = 0;
    busy_cnt = 0;
    sum_moved = 0;
    @(negedge clk);
    a8 = v.a; b8 = v.b; cin8 = v.cin; op8 = v.op; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1;
    while (!done8 && lat < 20) begin
      if (busy8) busy_cnt++;
      if (sum8 !== prev_sum) sum_moved = 1;
      if (glitch && lat == 3) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
      if (glitch && lat == 4) start8 = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    $display("op a=%02h b=%02h cin=%0b op=%0b -> sum=%02h cout=%0b lat=%0d",
             v.a, v.b, v.cin, v.op, sum8, cout8, lat);
    check("latency", lat, 8);
    check("busy_cycles", busy_cnt, 8);
    check("sum_held_during_run", {31'd0, sum_moved}, 0);
    check("busy_at_done", {31'd0, busy8}, 0);
    check("sum", {24'd0, sum8}, {24'd0, v.exp_sum});
    check("carry_out", {31'd0, cout8}, {31'd0, v.exp_cout});
    prev_sum = v.exp_sum;
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done8}, 0);
    check("sum_stable_after_done", {24'd0, sum8}, {24'd0, v.exp_sum});
  endtask

  task automatic run1(input logic a, input logic b, input logic c);
    int lat;
    logic [1:0] exp;
    lat = 0;
    exp = 2'(a) + 2'(b) + 2'(c);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    while (!done1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("w1 a=%0b b=%0b cin=%0b -> sum=%0b cout=%0b lat=%0d", a, b, c, sum1, cout1, lat);
    check("w1_latency", lat, 1);
    check("w1_sum", {31'd0, sum1}, {31'd0, exp[0]});
    check("w1_cout", {31'd0, cout1}, {31'd0, exp[1]});
  endtask

  initial begin
    int cyc;
    int ndone;
    int done_at[3];

    vecs.push_back('{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1});
    vecs.push_back('{8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0});
`ifdef SERIAL_ADDSUB_SUB_EN
    vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
    vecs.push_back('{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1});
`endif

    // Reset state
    #12;
    $display("reset: busy=%0b done=%0b sum=%02h cout=%0b", busy8, done8, sum8, cout8);
    check("rst_busy", {31'd0, busy8}, 0);
    check("rst_done", {31'd0, done8}, 0);
    check("rst_sum", {24'd0, sum8}, 0);
    check("rst_cout", {31'd0, cout8}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run8(vecs[i], 1'b0);

    // Start pulse during RUN must not restart the operation
    run8('{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0}, 1'b1);

    // Start held high: one result every 9 cycles
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; op8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    ndone = 0;
    while (ndone < 3 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done8) begin
        done_at[ndone] = cyc;
        $display("held start: done at cycle %0d sum=%02h cout=%0b", cyc, sum8, cout8);
        check("held_sum", {24'd0, sum8}, 32'h03);
        ndone++;
      end
    end
    start8 = 1'b0;
    check("held_done_count", ndone, 3);
    if (ndone == 3) begin
      check("held_first_done", done_at[0], 8);
      check("held_period_1", done_at[1] - done_at[0], 9);
      check("held_period_2", done_at[2] - done_at[1], 9);
    end
    @(posedge clk); #1;
    check("held_back_to_idle", {31'd0, busy8 | done8}, 0);
    prev_sum = 8'h03;

    // Reset four cycles into an operation
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("mid-run reset: busy=%0b done=%0b sum=%02h cout=%0b", busy8, done8, sum8, cout8);
    check("abort_busy", {31'd0, busy8}, 0);
    check("abort_done", {31'd0, done8}, 0);
    check("abort_sum", {24'd0, sum8}, 0);
    check("abort_cout", {31'd0, cout8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_sum = 8'h00;
    run8('{8'h21, 8'h43, 1'b1, 1'b0, 8'h65, 1'b0}, 1'b0);

    // Exhaustive one-bit sweep
    for (int i = 0; i < 8; i++) run1(i[2], i[1], i[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
